// File: rtl/intf_or_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : intf_or_arbiter
// Description : Round-robin arbiter that shares one intf_or unit (a/b action
//               methods, y actionvalue method) between N requesters, with
//               one transaction in flight at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module intf_or_arbiter #(
    parameter int N     = 2,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [N-1:0]     req_valid,
    input  logic [N-1:0]     req_a,
    input  logic [N-1:0]     req_b,
    output logic [N-1:0]     req_grant,
    output logic [N-1:0]     rsp_valid,
    output logic             rsp_data,
    input  logic [N-1:0]     rsp_ready,
    output logic             a_data,
    output logic             a_en,
    input  logic             a_rdy,
    output logic             b_data,
    output logic             b_en,
    input  logic             b_rdy,
    output logic             y_en,
    input  logic             y_data,
    input  logic             y_rdy,
    output logic             busy,
    output logic [CNT_W-1:0] txn_count
);

    // A single requester still keeps a 1-bit id/pointer.
    localparam int c_ID_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ISSUE  = 2'd1;
    localparam logic [1:0] c_WAIT_Y = 2'd2;
    localparam logic [1:0] c_RESP   = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [c_ID_W-1:0] r_ptr;
    logic [c_ID_W-1:0] r_id;
    logic              r_a;
    logic              r_b;
    logic              r_a_sent;
    logic              r_b_sent;
    logic              r_rsp_data;
    logic [CNT_W-1:0]  r_txn_count;

    logic              w_found;
    logic [c_ID_W-1:0] w_sel;
    logic [c_ID_W:0]   w_sum;
    logic [c_ID_W-1:0] w_ptr_next;
    logic [N-1:0]      w_grant;
    logic [N-1:0]      w_rsp_valid;
    logic              w_a_en;
    logic              w_b_en;
    logic              w_y_en;

    // Round-robin search: first valid requester starting at r_ptr, wrapping modulo N.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_sum   = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, r_ptr} + (c_ID_W+1)'(k);
            if (w_sum >= (c_ID_W+1)'(N)) begin
                w_sum = w_sum - (c_ID_W+1)'(N);
            end
            if (!w_found && req_valid[w_sum[c_ID_W-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_sum[c_ID_W-1:0];
            end
        end
    end

    assign w_ptr_next = (w_sel == c_ID_W'(N - 1)) ? '0 : w_sel + c_ID_W'(1);

    // Next-state logic and handshake strobes for each phase of a transaction.
    always_comb begin
        w_next_state = r_state;
        w_grant      = '0;
        w_rsp_valid  = '0;
        w_a_en       = 1'b0;
        w_b_en       = 1'b0;
        w_y_en       = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_found) begin
                    w_grant[w_sel] = 1'b1;
                    w_next_state   = c_ISSUE;
                end
            end
            c_ISSUE: begin
                w_a_en = a_rdy & ~r_a_sent;
                w_b_en = b_rdy & ~r_b_sent;
                if ((r_a_sent | w_a_en) & (r_b_sent | w_b_en)) begin
                    w_next_state = c_WAIT_Y;
                end
            end
            c_WAIT_Y: begin
                w_y_en = y_rdy;
                if (y_rdy) begin
                    w_next_state = c_RESP;
                end
            end
            c_RESP: begin
                w_rsp_valid[r_id] = 1'b1;
                if (rsp_ready[r_id]) begin
                    w_next_state = c_IDLE;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Operand/result latches, pointer, sent flags and transaction counter.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_ptr       <= '0;
            r_id        <= '0;
            r_a         <= 1'b0;
            r_b         <= 1'b0;
            r_a_sent    <= 1'b0;
            r_b_sent    <= 1'b0;
            r_rsp_data  <= 1'b0;
            r_txn_count <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_found) begin
                        r_a   <= req_a[w_sel];
                        r_b   <= req_b[w_sel];
                        r_id  <= w_sel;
                        r_ptr <= w_ptr_next;
                    end
                end
                c_ISSUE: begin
                    if (w_a_en) r_a_sent <= 1'b1;
                    if (w_b_en) r_b_sent <= 1'b1;
                end
                c_WAIT_Y: begin
                    if (y_rdy) r_rsp_data <= y_data;
                end
                c_RESP: begin
                    if (rsp_ready[r_id]) begin
                        r_txn_count <= r_txn_count + CNT_W'(1);
                        r_a_sent    <= 1'b0;
                        r_b_sent    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // The grant is combinational from req_valid, so it is gated to stay 0 during reset.
    assign req_grant = w_grant & {N{RST_N}};
    assign rsp_valid = w_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign a_data    = r_a;
    assign b_data    = r_b;
    assign a_en      = w_a_en;
    assign b_en      = w_b_en;
    assign y_en      = w_y_en;
    assign busy      = (r_state != c_IDLE);
    assign txn_count = r_txn_count;

endmodule
`default_nettype wire

// File: tb/tb_intf_or_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_intf_or_arbiter
// Description : Directed self-checking bench for intf_or_arbiter (N=2,
//               CNT_W=2) with a small behavioural stand-in for intf_or.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_intf_or_arbiter;

    logic       CLK;
    logic       RST_N;
    logic [1:0] req_valid;
    logic [1:0] req_a;
    logic [1:0] req_b;
    logic [1:0] req_grant;
    logic [1:0] rsp_valid;
    logic       rsp_data;
    logic [1:0] rsp_ready;
    logic       a_data;
    logic       a_en;
    logic       a_rdy;
    logic       b_data;
    logic       b_en;
    logic       b_rdy;
    logic       y_en;
    logic       y_data;
    logic       y_rdy;
    logic       busy;
    logic [1:0] txn_count;

    int checks   = 0;
    int failures = 0;

    logic        m_a = 1'b0;
    logic        m_b = 1'b0;
    logic [12:0] all_outs;

    intf_or_arbiter #(
        .N     (2),
        .CNT_W (2)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_grant (req_grant),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready),
        .a_data    (a_data),
        .a_en      (a_en),
        .a_rdy     (a_rdy),
        .b_data    (b_data),
        .b_en      (b_en),
        .b_rdy     (b_rdy),
        .y_en      (y_en),
        .y_data    (y_data),
        .y_rdy     (y_rdy),
        .busy      (busy),
        .txn_count (txn_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Stand-in for intf_or: capture operands on a/b, return their OR on y.
    always @(posedge CLK) begin
        if (a_en) m_a <= a_data;
        if (b_en) m_b <= b_data;
    end
    assign y_data = m_a | m_b;

    assign all_outs = {req_grant, rsp_valid, rsp_data, a_data, a_en,
                       b_data, b_en, y_en, busy, txn_count};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One full transaction with hand-computed expectations and optional stalls.
    task automatic run_txn(input string tag,
                           input logic [1:0] valid, input logic [1:0] a, input logic [1:0] b,
                           input logic [1:0] grant, input logic ea, input logic eb,
                           input logic ed, input logic [1:0] ecnt,
                           input int b_stall, input int y_stall, input int rsp_stall);
        req_valid = valid;
        req_a     = a;
        req_b     = b;
        rsp_ready = 2'b00;
        #1;
        check({tag, ".grant"}, 32'(req_grant), 32'(grant));
        check({tag, ".idle"},  32'(busy), 32'd0);
        tick();
        for (int i = 0; i <= b_stall; i++) begin
            a_rdy = 1'b1;
            b_rdy = (i == b_stall);
            y_rdy = 1'b1;
            #1;
            check({tag, ".a_en"},  32'(a_en), 32'(i == 0));
            check({tag, ".b_en"},  32'(b_en), 32'(i == b_stall));
            check({tag, ".y_en_issue"}, 32'(y_en), 32'd0);
            check({tag, ".grant_issue"}, 32'(req_grant), 32'd0);
            if (i == 0) begin
                check({tag, ".a_data"}, 32'(a_data), 32'(ea));
                check({tag, ".b_data"}, 32'(b_data), 32'(eb));
            end
            tick();
        end
        for (int i = 0; i <= y_stall; i++) begin
            y_rdy = (i == y_stall);
            #1;
            check({tag, ".y_en"}, 32'(y_en), 32'(i == y_stall));
            check({tag, ".ab_en_wait"}, 32'({a_en, b_en}), 32'd0);
            check({tag, ".rsp_valid_wait"}, 32'(rsp_valid), 32'd0);
            tick();
        end
        for (int i = 0; i <= rsp_stall; i++) begin
            rsp_ready = (i == rsp_stall) ? 2'b11 : ~grant;
            #1;
            check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(grant));
            check({tag, ".rsp_data"},  32'(rsp_data), 32'(ed));
            check({tag, ".grant_resp"}, 32'(req_grant), 32'd0);
            check({tag, ".busy_resp"}, 32'(busy), 32'd1);
            tick();
        end
        rsp_ready = 2'b00;
        #1;
        check({tag, ".txn_count"}, 32'(txn_count), 32'(ecnt));
        check({tag, ".busy_done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        RST_N     = 1'b0;
        req_valid = 2'b11;
        req_a     = 2'b00;
        req_b     = 2'b00;
        rsp_ready = 2'b00;
        a_rdy     = 1'b1;
        b_rdy     = 1'b1;
        y_rdy     = 1'b1;

        // Reset from power-up: every output 0 even with requesters valid.
        #12;
        check("rst_init_outs", 32'(all_outs), 32'd0);
        req_valid = 2'b00;
        RST_N     = 1'b1;
        tick();
        check("rst_rel_busy", 32'(busy), 32'd0);
        check("rst_rel_cnt",  32'(txn_count), 32'd0);

        // Reset in the middle of ISSUE abandons the transaction at once.
        req_valid = 2'b01;
        req_a     = 2'b01;
        req_b     = 2'b00;
        a_rdy     = 1'b0;
        b_rdy     = 1'b0;
        #1;
        check("mid_grant", 32'(req_grant), 32'h1);
        tick();
        check("mid_busy",   32'(busy), 32'd1);
        check("mid_a_data", 32'(a_data), 32'd1);
        check("mid_a_en",   32'(a_en), 32'd0);
        RST_N = 1'b0;
        #1;
        check("mid_rst_outs", 32'(all_outs), 32'd0);
        req_valid = 2'b00;
        tick();
        RST_N = 1'b1;
        tick();
        check("mid_rel_busy", 32'(busy), 32'd0);
        check("mid_rel_cnt",  32'(txn_count), 32'd0);
        a_rdy = 1'b1;
        b_rdy = 1'b1;

        // tag valid a b grant ea eb ed cnt b_stall y_stall rsp_stall
        run_txn("single",  2'b01, 2'b01, 2'b00, 2'b01, 1'b1, 1'b0, 1'b1, 2'd1, 0, 0, 0);
        run_txn("wrap_sr", 2'b01, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 2'd2, 0, 0, 0);
        run_txn("req1",    2'b10, 2'b00, 2'b10, 2'b10, 1'b0, 1'b1, 1'b1, 2'd3, 0, 0, 0);
        run_txn("rr0",     2'b11, 2'b11, 2'b00, 2'b01, 1'b1, 1'b0, 1'b1, 2'd0, 0, 0, 0);
        run_txn("rr1",     2'b11, 2'b00, 2'b10, 2'b10, 1'b0, 1'b1, 1'b1, 2'd1, 0, 0, 0);
        run_txn("rr2",     2'b11, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 2'd2, 0, 0, 0);
        run_txn("rr3",     2'b11, 2'b10, 2'b10, 2'b10, 1'b1, 1'b1, 1'b1, 2'd3, 0, 0, 0);
        run_txn("bp",      2'b01, 2'b00, 2'b01, 2'b01, 1'b0, 1'b1, 1'b1, 2'd0, 5, 3, 0);
        run_txn("stall",   2'b11, 2'b10, 2'b00, 2'b10, 1'b1, 1'b0, 1'b1, 2'd1, 0, 0, 4);

        // No requester valid: no grant, stays idle.
        req_valid = 2'b00;
        #1;
        check("none_grant", 32'(req_grant), 32'd0);
        tick();
        check("none_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
